pwm_capture: RTL
================

// Module: pwm_capture
// PURPOSE
//  Downstream measurement stage for the PWM generator output (dout).
//  Samples an asynchronous PWM line and measures, per cycle, the period and
//  high time in clk cycles. Presents each result on a valid/ready interface
//  and flags a stuck line (0% or 100% duty) after a timeout.
// PARAMETERS
//  CNT_W    16    width of period/high counters and result fields
//  TIMEOUT  1000  cycles without a qualifying edge before stuck-line report; must be < 2**CNT_W
//  FILT_LEN 3     stable cycles required by the input filter (PWM_CAP_FILTER_EN only)
// PORTS
//  clk         in   1      system clock
//  rst         in   1      asynchronous, active-high reset
//  pwm_in      in   1      PWM line under measurement (asynchronous to clk)
//  meas_ready  in   1      consumer accepts result when high with meas_valid
//  meas_valid  out  1      result fields valid; held until accepted
//  period_out  out  CNT_W  cycles between consecutive rising edges (0 = stuck line)
//  high_out    out  CNT_W  cycles from rising to falling edge (all-ones = stuck high)
//  overrun     out  1      sticky: an unaccepted result was overwritten
// BEHAVIOUR
//  - Reset (async, active-high): FSM=IDLE; counters, meas_valid, period_out, high_out, overrun=0.
//    Reset mid-measurement discards the partial count. Resumes on the next rising edge.
//  - Input path: 2-FF synchroniser -> optional filter -> 1-FF edge detector.
//    Fixed latency from pwm_in edge to detected edge is constant for both edges,
//    so it does not affect the measured widths.
//  - FSM states IDLE, HIGH, LOW:
//    IDLE: on rise -> HIGH, cnt_p=1, cnt_h=1.
//    HIGH: cnt_p++, cnt_h++ each cycle. On fall -> LOW, latch high_lat=cnt_h.
//    LOW:  cnt_p++. On rise -> publish (period=cnt_p, high=high_lat),
//          cnt_p=1, cnt_h=1, -> HIGH.
//    The first rise after IDLE never publishes.
//  - Timeout: if cnt_p reaches TIMEOUT in HIGH or LOW, or TIMEOUT cycles elapse in IDLE
//    with no edge, then:
//    publish period=0, high=0 (line low) or high={CNT_W{1}} (line high); -> IDLE.
//    Only one stuck report per stuck episode; the counter does not re-arm until an edge.
//  - Publish: period_out/high_out load; meas_valid=1 on the next cycle.
//  - Handshake: the result is held stable while meas_valid && !meas_ready.
//    meas_valid drops the cycle after the result is accepted, unless a new result publishes in that same cycle.
//    Publish while valid && !ready: overwrite, overrun=1.
//    Publish in the same cycle as accept: load new result, valid stays 1, no overrun.
//    Overrun clears on the next accept with no concurrent publish.
//  - Counters never wrap, because TIMEOUT < 2**CNT_W bounds them.
//  - Widths: period_out/high_out are unsigned CNT_W. cnt_h <= cnt_p always.
// CONFIGURATION
//  PWM_CAP_FILTER_EN defined:
//    - The filtered level changes only after the synced input differs from it for
//      FILT_LEN consecutive cycles.
//    - Pulses shorter than FILT_LEN are ignored.
//    - Edge latency grows by FILT_LEN.
//  PWM_CAP_FILTER_EN undefined: filtered level = synced input; any 1-cycle pulse is measured.
// STRUCTURE
//  Package pwm_pkg:
//    - FSM state encodings ST_IDLE/ST_HIGH/ST_LOW.
//    - Default CNT_W.
//    - STUCK_HIGH_CODE ({CNT_W{1}}), shared with the PWM generator bench.
//  Sub-module pwm_in_filter:
//    - synchroniser plus optional stability filter; outputs clean level.
//  Top level: edge detection, FSM, counters, result register and handshake.
// TESTING
//  1. Generator period=100, on=50, ready=1 -> after the 2nd rise, valid every 100 cycles, period_out=100, high_out=50.
//  2. on=30, ready=0 for 3 periods -> valid held, outputs=100/30, overrun=1; one accept -> overrun=0.
//  3. pwm_in held 0 for 1000 cycles -> one result 0/0, FSM IDLE.
//     pwm_in held 1 for 1000 cycles -> one result 0/16'hFFFF.
//     No repeat report until an edge.
//  4. rst asserted mid-HIGH phase -> all outputs 0 at once. After release, first result 100/50 appears only after two rises.
//  5. Filter built in (FILT_LEN=3), 1-cycle glitch in LOW -> results stay 100/50.
//     Filter not built in -> spurious short result reported.
//  6. on=1, filter not built in -> period_out=100, high_out=1. Accept coincident with publish -> valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture stage: FSM encodings, default result
// width and the stuck-high result code also used by the PWM generator bench.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [CNT_W_DEF-1:0] STUCK_HIGH_CODE = {CNT_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Result channel of the PWM capture stage: valid/ready handshake plus the
// measured period/high time and the sticky overrun flag.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);

  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             overrun;

  modport master (
    output meas_valid,
    output period_out,
    output high_out,
    output overrun,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  period_out,
    input  high_out,
    input  overrun,
    output meas_ready
  );

endinterface

// File: rtl/pwm_in_filter.sv
// Brings the asynchronous PWM line into the clk domain; with PWM_CAP_FILTER_EN
// defined, the level also has to stay stable for FILT_LEN cycles before it moves.
module pwm_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level
);

  logic sync_1;
  logic sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pwm_in;
      sync_2 <= sync_1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [FC_W-1:0] stable_cnt;

  // Counts consecutive cycles where the synced line disagrees with the output level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == FC_W'(FILT_LEN - 1)) begin
      level      <= sync_2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end
`else
  assign level = sync_2;
`endif

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("pwm_in_filter: FILT_LEN must be at least 1");
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles and reports
// stuck lines. Optional input glitch filter is built in with PWM_CAP_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int TIMEOUT  = 1000,
  parameter int FILT_LEN = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  pwm_capture_if.master meas
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
    $error("pwm_capture: TIMEOUT must be in 1 .. 2**CNT_W-1");
  end

  logic level;
  logic level_prev;
  logic rise;
  logic fall;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_p, cnt_p_nxt;
  logic [CNT_W-1:0] cnt_h, cnt_h_nxt;
  logic [CNT_W-1:0] high_lat, high_lat_nxt;
  logic             armed, armed_nxt;
  logic             pub;
  logic [CNT_W-1:0] pub_period;
  logic [CNT_W-1:0] pub_high;
  logic             accept;

  pwm_in_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_filter (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level)
  );

  assign rise   = level & ~level_prev;
  assign fall   = ~level & level_prev;
  assign accept = meas.meas_valid & meas.meas_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_prev <= 1'b0;
      state      <= ST_IDLE;
      cnt_p      <= '0;
      cnt_h      <= '0;
      high_lat   <= '0;
      armed      <= 1'b1;
    end else begin
      level_prev <= level;
      state      <= state_nxt;
      cnt_p      <= cnt_p_nxt;
      cnt_h      <= cnt_h_nxt;
      high_lat   <= high_lat_nxt;
      armed      <= armed_nxt;
    end
  end

  // Timeout wins over an edge in the same cycle so cnt_p never exceeds TIMEOUT.
  // After a stuck report 'armed' stays low until the line moves again.
  always_comb begin
    state_nxt    = state;
    cnt_p_nxt    = cnt_p;
    cnt_h_nxt    = cnt_h;
    high_lat_nxt = high_lat;
    armed_nxt    = armed;
    pub          = 1'b0;
    pub_period   = '0;
    pub_high     = '0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HIGH;
          cnt_p_nxt = CNT_W'(1);
          cnt_h_nxt = CNT_W'(1);
          armed_nxt = 1'b1;
        end else if (fall) begin
          cnt_p_nxt = '0;
          armed_nxt = 1'b1;
        end else if (armed) begin
          if (cnt_p == TIMEOUT_CNT) begin
            pub       = 1'b1;
            pub_high  = level ? '1 : '0;
            cnt_p_nxt = '0;
            armed_nxt = 1'b0;
          end else begin
            cnt_p_nxt = cnt_p + 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (cnt_p == TIMEOUT_CNT) begin
          pub       = 1'b1;
          pub_high  = '1;
          state_nxt = ST_IDLE;
          cnt_p_nxt = '0;
          cnt_h_nxt = '0;
          armed_nxt = 1'b0;
        end else if (fall) begin
          state_nxt    = ST_LOW;
          high_lat_nxt = cnt_h;
          cnt_p_nxt    = cnt_p + 1'b1;
        end else begin
          cnt_p_nxt = cnt_p + 1'b1;
          cnt_h_nxt = cnt_h + 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt_p == TIMEOUT_CNT) begin
          pub       = 1'b1;
          state_nxt = ST_IDLE;
          cnt_p_nxt = '0;
          cnt_h_nxt = '0;
          armed_nxt = 1'b0;
        end else if (rise) begin
          pub        = 1'b1;
          pub_period = cnt_p;
          pub_high   = high_lat;
          state_nxt  = ST_HIGH;
          cnt_p_nxt  = CNT_W'(1);
          cnt_h_nxt  = CNT_W'(1);
        end else begin
          cnt_p_nxt = cnt_p + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // A publish always lands; it only counts as an overrun if the old result was still unclaimed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas.meas_valid <= 1'b0;
      meas.period_out <= '0;
      meas.high_out   <= '0;
      meas.overrun    <= 1'b0;
    end else if (pub) begin
      meas.meas_valid <= 1'b1;
      meas.period_out <= pub_period;
      meas.high_out   <= pub_high;
      if (meas.meas_valid && !meas.meas_ready) begin
        meas.overrun <= 1'b1;
      end
    end else if (accept) begin
      meas.meas_valid <= 1'b0;
      meas.overrun    <= 1'b0;
    end
  end

endmodule
